// File: rtl/fir_stream_pkg.sv
// rtl/fir_stream_pkg.sv - shared FIR stream constants and saturation helper
package fir_stream_pkg;

  localparam int FIR_SAMPLE_WIDTH = 24;
  localparam int FIR_COEFF_WIDTH  = 24;
  localparam int FIR_NUM_TAPS     = 15;
  localparam int FIR_FRAC_SHIFT   = 23;
  localparam int FIR_ACC_WIDTH    = FIR_SAMPLE_WIDTH + FIR_COEFF_WIDTH + $clog2(FIR_NUM_TAPS);

  // Wide enough to hold any rounded accumulator value without loss.
  localparam int SAT_CALC_WIDTH   = 64;

  // Clamp a signed value into the range of a signed 'width'-bit integer.
  function automatic logic signed [SAT_CALC_WIDTH-1:0] sat_signed(
    input logic signed [SAT_CALC_WIDTH-1:0] value,
    input int                               width
  );
    logic signed [SAT_CALC_WIDTH-1:0] hi;
    logic signed [SAT_CALC_WIDTH-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - synchronous FIFO with count and same-cycle push/pop
module axis_sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_prev;
  logic             pop_ok;
  logic             push_ok;

  // A pop on an empty FIFO is ignored; a push when full is only taken alongside a pop.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  assign rd_prev = rd_ptr - AW'(1);

  // When empty, the read pointer sits one past the last popped entry, so
  // showing the previous slot keeps the output steady at its last value.
  always_comb begin
    head_data = mem[rd_ptr];
    if (count == '0) begin
      head_data = mem[rd_prev];
    end
  end

  // Storage, pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_output_requantizer.sv
// rtl/fir_output_requantizer.sv - round, saturate and buffer FIR output samples
module fir_output_requantizer
  import fir_stream_pkg::*;
#(
  parameter int IN_WIDTH   = FIR_ACC_WIDTH,
  parameter int OUT_WIDTH  = FIR_SAMPLE_WIDTH,
  parameter int FRAC_SHIFT = FIR_FRAC_SHIFT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           sat_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [IN_WIDTH:0] ROUND_K = (IN_WIDTH + 1)'(1) <<< (FRAC_SHIFT - 1);

  logic                             s_fire;
  logic signed [IN_WIDTH:0]         x_ext;
  logic signed [IN_WIDTH:0]         rnd_sum;
  logic signed [IN_WIDTH:0]         rnd_shift;

  logic                             v1;
  logic signed [IN_WIDTH:0]         r1;
  logic                             last1;

  logic signed [SAT_CALC_WIDTH-1:0] r1_wide;
  logic signed [SAT_CALC_WIDTH-1:0] sat_wide;
  logic                             clamp;

  logic                             v2;
  logic [OUT_WIDTH-1:0]             d2;
  logic                             last2;

  logic [CW-1:0]                    fifo_count;
  logic [CW:0]                      credit_sum;
  logic                             m_fire;

  // One extra bit keeps the half-LSB rounding add from overflowing.
  assign x_ext     = {s_axis_tdata[IN_WIDTH-1], s_axis_tdata};
  assign rnd_sum   = x_ext + ROUND_K;
  assign rnd_shift = rnd_sum >>> FRAC_SHIFT;

  assign r1_wide  = {{(SAT_CALC_WIDTH - IN_WIDTH - 1){r1[IN_WIDTH]}}, r1};
  assign sat_wide = sat_signed(r1_wide, OUT_WIDTH);
  assign clamp    = (sat_wide != r1_wide);

  // Credit counts every beat already committed to the FIFO, so the pipeline
  // never needs to stall; ready depends only on registered state.
  assign credit_sum    = {1'b0, fifo_count} + (CW + 1)'(v1) + (CW + 1)'(v2);
  assign s_axis_tready = reset_n && (credit_sum < (CW + 1)'(FIFO_DEPTH));
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = (fifo_count != '0);
  assign m_fire        = m_axis_tvalid && m_axis_tready;

  // Stage 1: capture the rounded value of each accepted beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1    <= 1'b0;
      r1    <= '0;
      last1 <= 1'b0;
    end else begin
      v1 <= s_fire;
      if (s_fire) begin
        r1    <= rnd_shift;
        last1 <= s_axis_tlast;
      end
    end
  end

  // Stage 2: clamp to the output width.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v2    <= 1'b0;
      d2    <= '0;
      last2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        d2    <= sat_wide[OUT_WIDTH-1:0];
        last2 <= last1;
      end
    end
  end

  // Saturation event counter, sticky at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_count <= '0;
    end else if (v1 && clamp && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

  axis_sync_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (v2),
    .push_data ({last2, d2}),
    .pop       (m_fire),
    .head_data ({m_axis_tlast, m_axis_tdata}),
    .count     (fifo_count)
  );

endmodule
